// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle: control and operands in, registered EX/MEM fields out.
// No latency of its own; it only carries signals between stages.
// Stall is the only backpressure. The master (upstream side) must hold all inputs while Stall is high.
// Ports: master drives RegWrite..shamt and receives Stall and M_*; slave is the reverse.
interface ex_stage_if #(
   parameter int XLEN = 32
);
   logic            RegWrite, MemtoReg, MemWrite, Branch;
   logic            ALUSrc, ALUSrc_shamt, RegDst;
   logic [3:0]      ALUControl;
   logic [XLEN-1:0] RD1, RD2, SignImm, PCplus4;
   logic [4:0]      Rt, Rd, shamt;
   logic            Stall;
   logic            M_RegWrite, M_MemtoReg, M_MemWrite, M_PCSrc;
   logic [XLEN-1:0] M_ALUOut, M_WriteData, M_PCBranch;
   logic [4:0]      M_WriteReg;

   modport master (
      output RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst,
      output ALUControl, RD1, RD2, SignImm, PCplus4, Rt, Rd, shamt,
      input  Stall,
      input  M_RegWrite, M_MemtoReg, M_MemWrite, M_PCSrc,
      input  M_ALUOut, M_WriteData, M_PCBranch, M_WriteReg
   );

   modport slave (
      input  RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst,
      input  ALUControl, RD1, RD2, SignImm, PCplus4, Rt, Rd, shamt,
      output Stall,
      output M_RegWrite, M_MemtoReg, M_MemWrite, M_PCSrc,
      output M_ALUOut, M_WriteData, M_PCBranch, M_WriteReg
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target and an iterative multiply/divide unit, registered into EX/MEM.
// Single-cycle ops take 1 cycle. MUL/DIVU/REMU occupy MD_CYCLES+2 cycles.
// Stall is combinational and high while an MD op is in flight; EX/MEM loads bubbles while Stall is high.
// Ports: CLK, RST_n (async active-low), ex (ex_stage_if.slave: ID/EX inputs, Stall, EX/MEM outputs).
// Option: define EX_MULDIV_EN to build the MD unit. Without it, codes 1100-1110 give 0 and Stall is tied low.
module ex_stage #(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input logic       CLK,
   input logic       RST_n,
   ex_stage_if.slave ex
);

   // The MD iteration count only works if it equals the datapath width.
   if (MD_CYCLES != XLEN) begin : g_cfg_chk
      $error("ex_stage: MD_CYCLES must equal XLEN");
   end

   logic [XLEN-1:0] src_a, src_b, alu_out, pc_branch, result;
   logic [4:0]      shift_amt, write_reg;
   logic            zero, stall;

   assign src_a     = ex.RD1;
   assign src_b     = ex.ALUSrc ? ex.SignImm : ex.RD2;
   assign shift_amt = ex.ALUSrc_shamt ? ex.shamt : ex.RD1[4:0];
   assign write_reg = ex.RegDst ? ex.Rd : ex.Rt;
   assign pc_branch = ex.PCplus4 + (ex.SignImm << 2);
   // (a - b) == 0 modulo 2^XLEN is the same as a == b
   assign zero      = (src_a == src_b);

   always_comb begin
      alu_out = '0;
      case (ex.ALUControl)
         4'b0000: alu_out = src_a & src_b;
         4'b0001: alu_out = src_a | src_b;
         4'b0010: alu_out = src_a + src_b;
         4'b0011: alu_out = src_a ^ src_b;
         4'b0100: alu_out = ~(src_a | src_b);
         4'b0110: alu_out = src_a - src_b;
         4'b0111: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'b1011: alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         4'b1000: alu_out = src_b << shift_amt;
         4'b1001: alu_out = src_b >> shift_amt;
         4'b1010: alu_out = $unsigned($signed(src_b) >>> shift_amt);
         default: alu_out = '0;   // 0101, 1111 and the MD codes
      endcase
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
   localparam int CW = $clog2(MD_CYCLES);

   md_state_t       state;
   logic [CW-1:0]   count;
   logic [1:0]      md_kind;     // latched ALUControl[1:0]: 00 MUL, 01 DIVU, 10 REMU
   logic [XLEN-1:0] md_acc;      // MUL partial product / DIV remainder
   logic [XLEN-1:0] md_x;        // MUL multiplicand (shifts left) / DIV divisor
   logic [XLEN-1:0] md_y;        // MUL multiplier (shifts right) / DIV dividend becoming quotient
   logic            md_req;
   logic [XLEN:0]   div_trial;
   logic [XLEN-1:0] div_diff, div_next, md_result;
   logic            div_ge;

   assign md_req = (ex.ALUControl[3:2] == 2'b11) && (ex.ALUControl[1:0] != 2'b11);
   // Gated by reset so Stall reads 0 while reset is held, even with an MD op at the inputs.
   assign stall  = RST_n && (((state == IDLE) && md_req) || (state == BUSY));

   // Restoring divide step. With a zero divisor every step "succeeds": the quotient fills with ones
   // and the remainder ends up holding the whole dividend.
   assign div_trial = {md_acc, md_y[XLEN-1]};
   assign div_ge    = (div_trial >= {1'b0, md_x});
   assign div_diff  = div_trial[XLEN-1:0] - md_x;
   assign div_next  = div_ge ? div_diff : div_trial[XLEN-1:0];

   always_comb begin
      md_result = md_acc;
      if (md_kind == 2'b01) md_result = md_y;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state   <= IDLE;
         count   <= '0;
         md_kind <= '0;
         md_acc  <= '0;
         md_x    <= '0;
         md_y    <= '0;
      end else begin
         case (state)
            IDLE: if (md_req) begin
               md_kind <= ex.ALUControl[1:0];
               md_acc  <= '0;
               count   <= '0;
               md_x    <= (ex.ALUControl[1:0] == 2'b00) ? src_a : src_b;
               md_y    <= (ex.ALUControl[1:0] == 2'b00) ? src_b : src_a;
               state   <= BUSY;
            end
            BUSY: begin
               if (md_kind == 2'b00) begin
                  if (md_y[0]) md_acc <= md_acc + md_x;
                  md_x <= md_x << 1;
                  md_y <= md_y >> 1;
               end else begin
                  md_acc <= div_next;
                  md_y   <= {md_y[XLEN-2:0], div_ge};
               end
               count <= count + 1'b1;
               if (count == CW'(MD_CYCLES - 1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign result = (state == DONE) ? md_result : alu_out;
`else
   assign stall  = 1'b0;
   assign result = alu_out;
`endif

   assign ex.Stall = stall;

   // EX/MEM boundary. A stalled cycle loads an all-zero bubble.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n || stall) begin
         ex.M_RegWrite  <= 1'b0;
         ex.M_MemtoReg  <= 1'b0;
         ex.M_MemWrite  <= 1'b0;
         ex.M_PCSrc     <= 1'b0;
         ex.M_ALUOut    <= '0;
         ex.M_WriteData <= '0;
         ex.M_PCBranch  <= '0;
         ex.M_WriteReg  <= '0;
      end else begin
         ex.M_RegWrite  <= ex.RegWrite;
         ex.M_MemtoReg  <= ex.MemtoReg;
         ex.M_MemWrite  <= ex.MemWrite;
         ex.M_PCSrc     <= ex.Branch & zero;
         ex.M_ALUOut    <= result;
         ex.M_WriteData <= ex.RD2;
         ex.M_PCBranch  <= pc_branch;
         ex.M_WriteReg  <= write_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random ops checked each cycle against a model.
// The model computes results with plain arithmetic and tracks MD occupancy as a countdown.
// The bench drives like an upstream stage and holds its inputs while a stall is expected.
module tb_ex_stage;
   localparam int XLEN      = 32;
   localparam int MD_CYCLES = 32;
`ifdef EX_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic CLK   = 1'b0;
   logic RST_n = 1'b1;
   always #5 CLK = ~CLK;

   ex_stage_if #(.XLEN(XLEN)) bus ();
   ex_stage #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) dut (.CLK(CLK), .RST_n(RST_n), .ex(bus));

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
      case (op)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return a + b;
         4'd3:  return a ^ b;
         4'd4:  return ~(a | b);
         4'd6:  return a - b;
         4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return b << sh;
         4'd9:  return b >> sh;
         4'd10: return $unsigned($signed(b) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd12:   return a * b;
         4'd13:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_md(input logic [3:0] op);
      return (op == 4'd12) || (op == 4'd13) || (op == 4'd14);
   endfunction

   function automatic logic [31:0] cur_srcb();
      return bus.ALUSrc ? bus.SignImm : bus.RD2;
   endfunction

   function automatic logic [4:0] cur_sh();
      return bus.ALUSrc_shamt ? bus.shamt : bus.RD1[4:0];
   endfunction

   // md_left: 0 = free; >1 = op in flight, stalling; 1 = result cycle
   int          md_left    = 0;
   logic [31:0] md_res     = '0;
   bit          last_stall = 1'b0;
   logic        e_rw = 0, e_mtr = 0, e_mw = 0, e_pcs = 0;
   logic [31:0] e_alu = '0, e_wd = '0, e_pcb = '0;
   logic [4:0]  e_wr = '0;

   function automatic bit model_stall();
      if (!RST_n)       return 1'b0;
      if (md_left > 1)  return 1'b1;
      if (md_left == 1) return 1'b0;
      return MD_EN && is_md(bus.ALUControl);
   endfunction

   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         md_left <= 0; md_res <= '0; last_stall <= 1'b0;
         e_rw <= 0; e_mtr <= 0; e_mw <= 0; e_pcs <= 0;
         e_alu <= '0; e_wd <= '0; e_pcb <= '0; e_wr <= '0;
      end else if (model_stall()) begin
         last_stall <= 1'b1;
         if (md_left == 0) begin
            md_res  <= ref_md(bus.ALUControl, bus.RD1, cur_srcb());
            md_left <= MD_CYCLES + 1;
         end else begin
            md_left <= md_left - 1;
         end
         e_rw <= 0; e_mtr <= 0; e_mw <= 0; e_pcs <= 0;
         e_alu <= '0; e_wd <= '0; e_pcb <= '0; e_wr <= '0;
      end else begin
         last_stall <= 1'b0;
         md_left    <= 0;
         e_rw  <= bus.RegWrite;
         e_mtr <= bus.MemtoReg;
         e_mw  <= bus.MemWrite;
         e_pcs <= bus.Branch && (bus.RD1 == cur_srcb());
         e_alu <= (md_left == 1) ? md_res : ref_alu(bus.ALUControl, bus.RD1, cur_srcb(), cur_sh());
         e_wd  <= bus.RD2;
         e_pcb <= bus.PCplus4 + (bus.SignImm << 2);
         e_wr  <= bus.RegDst ? bus.Rd : bus.Rt;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (chk_en && RST_n) begin
         chk("stall",    32'(bus.Stall), 32'(model_stall()));
         chk("ctrl",     32'({bus.M_RegWrite, bus.M_MemtoReg, bus.M_MemWrite, bus.M_PCSrc}),
                         32'({e_rw, e_mtr, e_mw, e_pcs}));
         chk("aluout",   bus.M_ALUOut, e_alu);
         chk("wdata",    bus.M_WriteData, e_wd);
         chk("pcbranch", bus.M_PCBranch, e_pcb);
         chk("writereg", 32'(bus.M_WriteReg), 32'(e_wr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_op(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic alusrc,
                         input logic shsel, input logic [4:0] sh, input logic rw, input logic br);
      bus.ALUControl = op;  bus.RD1 = rd1; bus.RD2 = rd2; bus.SignImm = imm; bus.PCplus4 = pc4;
      bus.ALUSrc = alusrc;  bus.ALUSrc_shamt = shsel; bus.shamt = sh;
      bus.RegWrite = rw;    bus.Branch = br; bus.MemtoReg = 1'b0; bus.MemWrite = 1'b0;
      bus.RegDst = 1'b1;    bus.Rt = 5'd3; bus.Rd = 5'd7;
   endtask

   // Holds the current inputs until the op is accepted; returns cycles taken and DUT stall cycles seen.
   task automatic issue(output int cycles, output int dut_stalls);
      cycles = 0; dut_stalls = 0;
      do begin
         #1;
         if (bus.Stall) dut_stalls++;
         @(posedge CLK); #2;
         cycles++;
      end while (last_stall && cycles < 200);
      if (last_stall) chk("issue_timeout", 32'(last_stall), 32'd0);
   endtask

   int cyc, stl;

   initial begin
      set_op(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 RST_n = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      chk("reset_ctrl", 32'({bus.M_RegWrite, bus.M_MemtoReg, bus.M_MemWrite, bus.M_PCSrc}), 32'd0);
      chk("reset_aluout", bus.M_ALUOut, 32'd0);
      chk("reset_stall", 32'(bus.Stall), 32'd0);
      RST_n  = 1'b1;
      chk_en = 1'b1;

      // reset while the MD unit is on iteration 10
      set_op(4'd12, 32'h1234, 32'h5678, 0, 32'h40, 0, 0, 0, 1, 1);
      repeat (11) @(posedge CLK);
      #2 RST_n = 1'b0;
      #1;
      chk("midmd_rst_stall", 32'(bus.Stall), 32'd0);
      chk("midmd_rst_ctrl", 32'({bus.M_RegWrite, bus.M_MemtoReg, bus.M_MemWrite, bus.M_PCSrc}), 32'd0);
      chk("midmd_rst_aluout", bus.M_ALUOut, 32'd0);
      chk("midmd_rst_pcbranch", bus.M_PCBranch, 32'd0);
      #3 RST_n = 1'b1;
      set_op(4'd2, 3, 4, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("add_after_reset", bus.M_ALUOut, 32'd7);

      // SUB with immediate and branch
      set_op(4'd6, 5, 32'h99, 5, 32'h100, 1, 0, 0, 1, 1);
      issue(cyc, stl);
      chk("sub_aluout", bus.M_ALUOut, 32'd0);
      chk("sub_pcsrc", 32'(bus.M_PCSrc), 32'd1);
      chk("sub_pcbranch", bus.M_PCBranch, 32'h114);
      set_op(4'd6, 6, 32'h99, 5, 32'h100, 1, 0, 0, 1, 1);
      issue(cyc, stl);
      chk("sub_ne_pcsrc", 32'(bus.M_PCSrc), 32'd0);

      // shifts
      set_op(4'd10, 0, 32'h8000_0000, 0, 0, 0, 1, 4, 1, 0);
      issue(cyc, stl);
      chk("sra", bus.M_ALUOut, 32'hF800_0000);
      set_op(4'd8, 33, 1, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("sll_rd1_shamt", bus.M_ALUOut, 32'd2);

      // MUL, then an ADD right behind it
      set_op(4'd12, 32'hFFFF, 32'h10001, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("mul_stall_cycles", 32'(stl), MD_EN ? 32'd33 : 32'd0);
      chk("mul_total_cycles", 32'(cyc), MD_EN ? 32'd34 : 32'd1);
      chk("mul_aluout", bus.M_ALUOut, MD_EN ? 32'hFFFF_FFFF : 32'd0);
      chk("mul_regwrite", 32'(bus.M_RegWrite), 32'd1);
      set_op(4'd2, 10, 20, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("b2b_add_cycles", 32'(cyc), 32'd1);
      chk("b2b_add_aluout", bus.M_ALUOut, 32'd30);

      // divide
      set_op(4'd13, 100, 7, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("divu", bus.M_ALUOut, MD_EN ? 32'd14 : 32'd0);
      set_op(4'd14, 100, 7, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("remu", bus.M_ALUOut, MD_EN ? 32'd2 : 32'd0);
      set_op(4'd13, 9, 0, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("divu_by0", bus.M_ALUOut, MD_EN ? 32'hFFFF_FFFF : 32'd0);
      chk("divu_by0_cycles", 32'(cyc), MD_EN ? 32'd34 : 32'd1);
      set_op(4'd14, 9, 0, 0, 0, 0, 0, 0, 1, 0);
      issue(cyc, stl);
      chk("remu_by0", bus.M_ALUOut, MD_EN ? 32'd9 : 32'd0);
      chk("remu_by0_cycles", 32'(cyc), MD_EN ? 32'd34 : 32'd1);

      // random ops, checked every cycle by the compare process
      for (int i = 0; i < 400; i++) begin
         bus.ALUControl   = 4'($urandom_range(0, 15));
         bus.RD1          = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         bus.RD2          = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         bus.SignImm      = ($urandom_range(0, 3) == 0) ? bus.RD1 : $urandom;
         bus.PCplus4      = $urandom;
         bus.ALUSrc       = 1'($urandom);
         bus.ALUSrc_shamt = 1'($urandom);
         bus.shamt        = 5'($urandom);
         bus.RegWrite     = 1'($urandom);
         bus.MemtoReg     = 1'($urandom);
         bus.MemWrite     = 1'($urandom);
         bus.Branch       = 1'($urandom);
         bus.RegDst       = 1'($urandom);
         bus.Rt           = 5'($urandom);
         bus.Rd           = 5'($urandom);
         issue(cyc, stl);
      end

      set_op(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #2 chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register; consumes its control and data outputs.
- Performs ALU operations, branch-target calculation and iterative 32-cycle multiply/divide.
- Registers results into the EX/MEM boundary.
- Asserts Stall while a multi-cycle op is in flight; PC, IF/ID and ID/EX enables hold on Stall.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations for multiply/divide; must equal XLEN.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst  in  1 each  control from ID/EX.
- ALUControl  in  4  operation code.
- RD1, RD2, SignImm, PCplus4  in  32 each  operands from ID/EX.
- Rt, Rd, shamt  in  5 each  register fields and shift amount.
- Stall  out  1  combinational; hold upstream stages.
- M_RegWrite, M_MemtoReg, M_MemWrite, M_PCSrc  out  1 each  registered EX/MEM control; M_PCSrc = Branch & Zero.
- M_ALUOut, M_WriteData, M_PCBranch  out  32 each  registered result, store data (RD2) and branch target.
- M_WriteReg  out  5  registered destination register.

Behaviour:
- Reset: all M_* outputs are 0, the FSM is IDLE, the counter is 0 and Stall is 0. Reset applies immediately and asynchronously, including mid-multiply/divide; the partial result is discarded.
- Operand selection:
  - SrcA = RD1.
  - SrcB = ALUSrc ? SignImm : RD2.
  - Shift amount = ALUSrc_shamt ? shamt : RD1[4:0]; the shifted value is SrcB.
- Other datapath values:
  - WriteReg = RegDst ? Rd : Rt.
  - PCBranch = PCplus4 + (SignImm << 2), modulo 2^32.
  - Zero = (SrcA - SrcB) == 0, evaluated for every op.
- ALUControl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed), 1011 SLTU.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1100 MUL (low 32 bits of product), 1101 DIVU quotient, 1110 REMU remainder.
  - 0101 and 1111 produce ALUOut = 0.
  - Add and sub wrap; there is no overflow trap.
- Single-cycle ops: EX/MEM captures the result on the next rising edge (latency 1); Stall stays 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with an MD op (1100–1110) at the inputs: Stall = 1; latch operands; counter = 0; go to BUSY.
  - BUSY: Stall = 1; one shift-add (MUL) or restoring-divide step per cycle; counter increments. At counter == MD_CYCLES-1, go to DONE.
  - DONE: Stall = 0; EX/MEM captures the MD result together with the current control inputs; go to IDLE.
  - MD total occupancy: MD_CYCLES + 2 cycles (34 with the default).
- While Stall = 1, EX/MEM loads a bubble: all M_* controls are 0 and the data fields are 0.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend; still takes the full cycle count.
- Back-to-back MD ops: the second op is seen in IDLE the cycle after DONE and starts a new sequence. There is no overlap.
- The FSM ignores input changes while in BUSY; operands are latched.

Optional Feature:
- Macro EX_MULDIV_EN.
- Defined: MD FSM and codes 1100–1110 are implemented as above.
- Undefined:
  - No FSM is generated and Stall is tied to 0.
  - Codes 1100–1110 behave like 0101 and 1111: single-cycle, ALUOut = 0.
  - Control outputs pass through normally.

Test Plan:
- Reset: assert RST_n = 0 during BUSY at counter 10 -> all M_* = 0 and Stall = 0 immediately. After release, an ADD 3 + 4 gives M_ALUOut = 7 one cycle later.
- ALU/immediate: ALUControl = 0110, RD1 = 5, ALUSrc = 1, SignImm = 5, Branch = 1, PCplus4 = 0x100 -> M_ALUOut = 0, M_PCSrc = 1, M_PCBranch = 0x114. The same op with RD1 = 6 -> M_PCSrc = 0.
- Shifts:
  - SRA, ALUSrc_shamt = 1, shamt = 4, RD2 = 0x80000000 -> M_ALUOut = 0xF8000000.
  - SLL, ALUSrc_shamt = 0, RD1 = 33, RD2 = 1 -> M_ALUOut = 2 (shift amount 1).
- MUL: RD1 = 0xFFFF, RD2 = 0x10001, RegWrite = 1 -> Stall high for 33 cycles, low in DONE. M_ALUOut = 0xFFFFFFFF and M_RegWrite = 1 after 34 cycles; M_RegWrite = 0 throughout the bubble cycles.
- DIVU/REMU:
  - 100 / 7 -> quotient 14; REMU -> remainder 2.
  - Divide by zero with RD1 = 9 -> DIVU gives 0xFFFFFFFF, REMU gives 9; each takes 34 cycles.
- Back-to-back MUL then ADD: the ADD result appears exactly one cycle after the MUL result, with no lost or duplicated writeback. Repeat with EX_MULDIV_EN undefined -> Stall never asserts and MUL gives M_ALUOut = 0.
